// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, programmable almost-flags,
// sticky overflow/underflow errors and a selectable show-ahead or registered read port.
module sync_fifo_ctrl #(
    parameter int DSIZE         = 8,
    parameter int ASIZE         = 3,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = (1 << ASIZE) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    output logic             wovf,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic             runf,
    output logic [ASIZE:0]   count
);

    localparam int MEMDEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT  = (ASIZE + 1)'(MEMDEPTH);
    localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE + 1)'(AFULL_THRESH);
    localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE + 1)'(AEMPTY_THRESH);

    logic [DSIZE-1:0] mem [MEMDEPTH];

    logic [ASIZE:0] wptr_reg;
    logic [ASIZE:0] wptr_next;
    logic [ASIZE:0] rptr_reg;
    logic [ASIZE:0] rptr_next;
    logic [ASIZE:0] count_reg;
    logic [ASIZE:0] count_next;
    logic           wovf_reg;
    logic           wovf_next;
    logic           runf_reg;
    logic           runf_next;
    logic           wr_en;
    logic           rd_en;

    // Status flags come only from the registered count, so a request is
    // accepted or rejected against the state settled at the previous edge.
    assign wfull         = (count_reg == DEPTH_CNT);
    assign rempty        = (count_reg == '0);
    assign walmost_full  = (count_reg >= AFULL_CNT);
    assign ralmost_empty = (count_reg <= AEMPTY_CNT);
    assign wovf          = wovf_reg;
    assign runf          = runf_reg;
    assign count         = count_reg;

    // Requests arriving while reset is asserted are dropped outright.
    assign wr_en = winc && !wfull && !rst;
    assign rd_en = rinc && !rempty && !rst;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        wovf_next  = wovf_reg | (winc && wfull);
        runf_next  = runf_reg | (rinc && rempty);
        if (wr_en) begin
            wptr_next = wptr_reg + 1'b1;
        end
        if (rd_en) begin
            rptr_next = rptr_reg + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            wovf_reg  <= 1'b0;
            runf_reg  <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            wovf_reg  <= wovf_next;
            runf_reg  <= runf_next;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_reg[ASIZE-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_show_ahead
            // Head entry is presented combinationally; valid whenever non-empty.
            assign rdata  = mem[rptr_reg[ASIZE-1:0]];
            assign rvalid = !rempty;
        end else begin : g_registered
            logic [DSIZE-1:0] rdata_reg;
            logic             rvalid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_en;
                    if (rd_en) begin
                        rdata_reg <= mem[rptr_reg[ASIZE-1:0]];
                    end
                end
            end

            assign rdata  = rdata_reg;
            assign rvalid = rvalid_reg;
        end
    endgenerate

    // Occupancy must always agree with the pointer distance.
    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        count_reg == (wptr_reg - rptr_reg));

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO for transfers where producer and consumer share one clock domain.
- Successor to the team's dual-clock behavioural FIFO. Adds:
  - synchronous reset;
  - occupancy count output;
  - programmable almost-full and almost-empty flags;
  - sticky overflow and underflow error flags;
  - selectable read mode: show-ahead (FWFT) or registered 1-cycle read.
- Sits between stream producers and consumers inside a single clock domain; a drop-in where the async FIFO is overkill.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 3, address width; depth MEMDEPTH = 1<<ASIZE entries.
- FWFT, 1:
  - 1 = show-ahead: rdata always presents the head entry.
  - 0 = registered read: rdata is valid 1 cycle after an accepted read.
- AFULL_THRESH, MEMDEPTH-1, walmost_full asserts when count >= this value. Legal range 1..MEMDEPTH.
- AEMPTY_THRESH, 1, ralmost_empty asserts when count <= this value. Legal range 0..MEMDEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- wdata  input  DSIZE  write data.
- winc  input  1  write request; accepted when winc && !wfull.
- wfull  output  1  FIFO holds MEMDEPTH entries.
- walmost_full  output  1  count >= AFULL_THRESH.
- wovf  output  1  sticky: a write was attempted while full.
- rinc  input  1  read request; accepted when rinc && !rempty.
- rdata  output  DSIZE  read data (timing per FWFT).
- rvalid  output  1  FWFT=0: rdata updated this cycle. FWFT=1: equals !rempty.
- rempty  output  1  FIFO holds 0 entries.
- ralmost_empty  output  1  count <= AEMPTY_THRESH.
- runf  output  1  sticky: a read was attempted while empty.
- count  output  ASIZE+1  current occupancy, 0..MEMDEPTH.

Behaviour:
- Storage and pointers:
  - Storage is an array of MEMDEPTH x DSIZE. Memory contents are not reset.
  - wptr and rptr are ASIZE+1-bit binary pointers. Memory is indexed by the low ASIZE bits; the MSB distinguishes full from empty on wrap.
- Reset (rst=1 at posedge clk), regardless of in-flight requests, which are dropped:
  - wptr=0, rptr=0, count=0.
  - wovf=0, runf=0.
  - rvalid=0 and FWFT=0 rdata register=0.
  - Resulting outputs: rempty=1, wfull=0, ralmost_empty=1, walmost_full=0.
- Accepted write: mem[wptr[ASIZE-1:0]]<=wdata; wptr<=wptr+1.
- Accepted read: rptr<=rptr+1.
- count register:
  - +1 on write-only.
  - -1 on read-only.
  - unchanged when both a write and a read are accepted, or neither.
  - count == wptr-rptr (mod 2^(ASIZE+1)) at all times; this is an assertion.
- Flags:
  - wfull = (count==MEMDEPTH); rempty = (count==0).
  - Almost-flags are compares on the registered count.
  - All flags are combinational from registers, so they reflect an operation in the cycle after its accepting edge.
- Simultaneous events:
  - Full with winc && rinc: the read is accepted and the write is rejected (wfull gates the write). count becomes MEMDEPTH-1 and wovf is set.
  - Empty with winc && rinc: the write is accepted and the read is rejected. count becomes 1 and runf is set.
  - Neither full nor empty: both are accepted and count is unchanged.
- Errors: wovf sets on winc && wfull; runf sets on rinc && rempty. Both hold until rst. The FIFO state is unchanged by a rejected request.
- FWFT=1:
  - rdata = mem[rptr[ASIZE-1:0]], combinational.
  - The first written word appears on rdata the cycle after its write edge. rvalid = !rempty.
- FWFT=0:
  - On an accepted read, the rdata register <= mem[rptr[ASIZE-1:0]] and rvalid<=1 for exactly one cycle.
  - Otherwise rdata holds its value and rvalid<=0.
  - Read latency is 1 cycle.
- Wrap-around: the pointers wrap naturally at 2^(ASIZE+1). Full and empty are derived from count, never from pointer compare alone.

Test Plan:
- Reset/idle: assert rst for 2 cycles with winc=rinc=1 -> count=0, rempty=1, wfull=0, ralmost_empty=1, wovf=0, runf=0, rvalid=0.
- Fill/overflow (DSIZE=8, ASIZE=3): write 0x10..0x17 -> count=8, wfull=1, walmost_full asserted from count=7. A 9th write of 0xFF -> wovf=1, count stays 8, 0xFF never read back.
- Drain/underflow with FWFT=1:
  - Read 8 times -> rdata sequence 0x10..0x17 with rdata valid in the same cycle as rinc.
  - Then rempty=1; a further rinc -> runf=1 and count stays 0.
- Registered read (FWFT=0): write 0xA5, 0x5A, then rinc on 2 consecutive cycles -> rvalid high on the 2 following cycles with rdata 0xA5, then 0x5A. rdata holds 0x5A afterwards.
- Simultaneous ops:
  - At count=8, winc+rinc -> count=7, wovf=1.
  - At count=0, winc+rinc -> count=1, runf=1.
  - At count=4, 20 cycles of winc+rinc with an incrementing pattern -> count stays 4, data order preserved across pointer wrap.
- Mid-operation reset: at count=5, assert rst together with winc -> next cycle count=0, rempty=1. A subsequent write of 0x3C then read returns 0x3C.
